// File: rtl/mini_tpu.sv
// mini_tpu: 4x4 output-stationary systolic matrix-multiply engine (C = A x B).
// A rows stream in from the left edge, B columns from the top edge, each skewed
// by its index so that PE(i,j) sees A[i][k] and B[k][j] together at step i+j+k.
// Results stay in the PE accumulators and are read out one byte at a time by STORE.
module mini_tpu #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instruction,
  output logic [7:0]  result
);

  localparam int IW = $clog2(N);
  localparam int PW = 2 * DATA_W;
  // Last active step is 3*(N-1); the counter parks one past it.
  localparam logic [3:0] STEP_DONE = 4'(3 * N - 2);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  logic [1:0]        op;
  logic [1:0]        sel;
  logic [IW-1:0]     row;
  logic [IW-1:0]     col;
  logic [DATA_W-1:0] data;

  assign op   = instruction[15:14];
  assign sel  = instruction[13:12];
  assign row  = instruction[11:10];
  assign col  = instruction[9:8];
  assign data = instruction[7:0];

  logic [DATA_W-1:0] mat_a [N][N];
  logic [DATA_W-1:0] mat_b [N][N];
  logic [ACC_W-1:0]  acc   [N][N];
  logic [3:0]        step;

  // Operands presented to each PE this step (edge feed or neighbour register).
  logic [DATA_W-1:0] a_p0  [N][N];
  logic [DATA_W-1:0] b_p0  [N][N];
  logic [PW-1:0]     prod_p0 [N][N];
  // Operands latched by each PE for its right / lower neighbour.
  logic [DATA_W-1:0] a_p1  [N][N];
  logic [DATA_W-1:0] b_p1  [N][N];

  logic run_en;
  assign run_en = (op == OP_RUN) && (step != STEP_DONE);

  function automatic logic [ACC_W-1:0] widen(input logic [PW-1:0] p);
    return ACC_W'(p);
  endfunction

  function automatic logic [7:0] low_byte(input logic [ACC_W-1:0] v);
    return v[7:0];
  endfunction

  // Stage p0: skewed edge feeds plus neighbour operands; internal paths read
  // as zero on step 0 so stale operands from an earlier run never re-enter.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_p0[i][j] = '0;
        b_p0[i][j] = '0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if ((step >= 4'(i)) && ((step - 4'(i)) < 4'(N)))
        a_p0[i][0] = mat_a[i][IW'(step - 4'(i))];
      for (int j = 1; j < N; j++)
        a_p0[i][j] = (step == 4'd0) ? '0 : a_p1[i][j-1];
    end
    for (int j = 0; j < N; j++) begin
      if ((step >= 4'(j)) && ((step - 4'(j)) < 4'(N)))
        b_p0[0][j] = mat_b[IW'(step - 4'(j))][j];
      for (int i = 1; i < N; i++)
        b_p0[i][j] = (step == 4'd0) ? '0 : b_p1[i-1][j];
    end
  end

  // Per-PE unsigned multiply.
  always_comb begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        prod_p0[i][j] = a_p0[i][j] * b_p0[i][j];
  end

  // Stage p1: operand shift registers advance only on an active RUN.
  always_ff @(posedge clk) begin
    if (run_en && !rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_p1[i][j] <= a_p0[i][j];
          b_p1[i][j] <= b_p0[i][j];
        end
      end
    end
  end

  // Instruction decode: matrix loads, step counter, accumulators, result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          mat_a[i][j] <= '0;
          mat_b[i][j] <= '0;
          acc[i][j]   <= '0;
        end
      end
      step   <= '0;
      result <= '0;
    end else begin
      case (op)
        OP_LOAD: begin
          step <= '0;
          if (sel == 2'b00)
            mat_a[row][col] <= data;
          else if (sel == 2'b10)
            mat_b[row][col] <= data;
        end
        OP_RUN: begin
          if (run_en) begin
            step <= step + 4'd1;
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                // First step of a run overwrites, discarding any previous result.
                if (step == 4'd0)
                  acc[i][j] <= widen(prod_p0[i][j]);
                else
                  acc[i][j] <= acc[i][j] + widen(prod_p0[i][j]);
              end
            end
          end
        end
        OP_STORE: result <= low_byte(acc[row][col]);
        OP_NOP:   ;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_tpu.sv
// Directed bench for mini_tpu: loads matrices, runs the array, stores results
// and compares each returned byte with a hand-computed value.
module tb_mini_tpu;

  logic        clk;
  logic        rst;
  logic [15:0] instruction;
  logic [7:0]  result;

  int vectors = 0;
  int errors  = 0;

  mini_tpu dut (
    .clk(clk),
    .rst(rst),
    .instruction(instruction),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic [15:0] ins);
    instruction = ins;
    @(posedge clk);
    #1;
    instruction = 16'h0000;
  endtask

  task automatic load(input logic [1:0] sel, input int r, input int c, input logic [7:0] d);
    tick({2'b10, sel, 2'(r), 2'(c), d});
  endtask

  task automatic run(input int n);
    repeat (n) tick({2'b01, 14'h0000});
  endtask

  task automatic check(input logic [7:0] exp, input string tag);
    vectors++;
    assert (result === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, result, exp);
    end
  endtask

  task automatic store_chk(input int r, input int c, input logic [7:0] exp, input string tag);
    tick({2'b11, 2'b00, 2'(r), 2'(c), 8'h00});
    check(exp, tag);
  endtask

  task automatic check_all(input logic [7:0] exp, input string tag);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        store_chk(r, c, exp, $sformatf("%s(%0d,%0d)", tag, r, c));
  endtask

  task automatic load_const(input logic [7:0] av, input logic [7:0] bv);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        load(2'b00, r, c, av);
        load(2'b10, r, c, bv);
      end
  endtask

  // A = identity, B = 1..16 row-major.
  task automatic load_test1();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        load(2'b00, r, c, (r == c) ? 8'h01 : 8'h00);
        load(2'b10, r, c, 8'(r * 4 + c + 1));
      end
  endtask

  initial begin
    rst = 1'b1;
    instruction = 16'h0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check(8'h00, "reset_result");
    store_chk(2, 1, 8'h00, "reset_acc");

    // Identity times B returns B.
    load_test1();
    run(10);
    store_chk(1, 2, 8'h07, "t1_c12");
    store_chk(3, 3, 8'h10, "t1_c33");
    store_chk(0, 0, 8'h01, "t1_c00");
    store_chk(2, 1, 8'h0A, "t1_c21");

    // Constant matrices: 4*2*3 = 24.
    load_const(8'h02, 8'h03);
    run(10);
    check_all(8'h18, "t2");

    // Full-scale operands: 4*255*255 = 0x3F804, low byte 0x04.
    load_const(8'hFF, 8'hFF);
    run(10);
    check_all(8'h04, "t3");

    // Partial results after a single RUN, then saturation of the step counter.
    load_const(8'h02, 8'h03);
    run(1);
    store_chk(0, 0, 8'h06, "t4_p00");
    store_chk(0, 1, 8'h00, "t4_p01");
    store_chk(3, 3, 8'h00, "t4_p33");
    run(9);
    store_chk(3, 3, 8'h18, "t4_f33");
    run(5);
    check_all(8'h18, "t4_extra");
    run(1);
    check(8'h18, "t4_hold");

    // Reset mid-run clears matrices and accumulators.
    load_test1();
    run(4);
    rst = 1'b1;
    tick({2'b01, 14'h0000});
    rst = 1'b0;
    check(8'h00, "t5_rst_result");
    check_all(8'h00, "t5_rst");
    run(10);
    store_chk(3, 3, 8'h00, "t5_zero_run");
    load_test1();
    run(10);
    store_chk(1, 2, 8'h07, "t5_c12");
    store_chk(3, 3, 8'h10, "t5_c33");

    // Single-element reload and ignored sel=01 LOAD; row 0 = 5*3 + 3*2*3 = 33.
    load_const(8'h02, 8'h03);
    run(10);
    load(2'b00, 0, 0, 8'h05);
    load(2'b01, 0, 0, 8'h09);
    load(2'b01, 1, 1, 8'h09);
    store_chk(0, 0, 8'h18, "t6_acc_kept");
    run(10);
    store_chk(0, 0, 8'h21, "t6_c00");
    store_chk(0, 3, 8'h21, "t6_c03");
    store_chk(1, 1, 8'h18, "t6_c11");
    store_chk(3, 0, 8'h18, "t6_c30");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
